// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver framing command/data byte pairs for J1 with ready/ack handshake
module uart_cmd_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ack_j1,
  output logic [7:0] comando_rx,
  output logic [7:0] datos_rx,
  output logic       rx_ready,
  output logic       bussy,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_V = TW'(TO);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_t;
  typedef enum logic {WAIT_CMD, WAIT_DATA} asm_t;
  bit_t bit_st, bit_n;
  asm_t asm_st, asm_n;
  logic rx_m, rx_s, rx_p, fall;
  logic [CW-1:0] cc, cc_n;
  logic [2:0] bc, bc_n;
  logic [7:0] shift, shift_n, cmd_hold, cmd_hold_n;
  logic [TW-1:0] tmr, tmr_n;
  logic byte_done, ferr, load, ovr;
  assign fall = rx_p & ~rx_s;
  always_comb begin
    bit_n = bit_st;
    cc_n = cc + 1'b1;
    bc_n = bc;
    shift_n = shift;
    byte_done = 1'b0;
    ferr = 1'b0;
    case (bit_st)
      IDLE: begin
        cc_n = '0;
        bit_n = fall ? START : IDLE;
      end
      START: if (cc == HALF_M1) begin
        cc_n = '0;
        bc_n = '0;
        bit_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cc == FULL_M1) begin
        cc_n = '0;
        shift_n[bc] = rx_s;
        bc_n = bc + 3'd1;
        bit_n = (bc == 3'd7) ? STOP : DATA;
      end
      default: if (cc == FULL_M1) begin
        cc_n = '0;
        bit_n = IDLE;
        byte_done = rx_s;
        ferr = ~rx_s;
      end
    endcase
    asm_n = asm_st;
    cmd_hold_n = cmd_hold;
    tmr_n = (bit_st == IDLE) ? tmr + 1'b1 : '0;
    load = 1'b0;
    ovr = 1'b0;
    if (asm_st == WAIT_CMD) begin
      tmr_n = '0;
      cmd_hold_n = byte_done ? shift : cmd_hold;
      asm_n = byte_done ? WAIT_DATA : WAIT_CMD;
    end else begin
      load = byte_done & (~rx_ready | ack_j1);
      ovr = byte_done & rx_ready & ~ack_j1;
      asm_n = (byte_done | ferr | tmr == TO_V) ? WAIT_CMD : WAIT_DATA;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
      bit_st <= IDLE;
      asm_st <= WAIT_CMD;
      cc <= '0;
      bc <= '0;
      shift <= '0;
      cmd_hold <= '0;
      tmr <= '0;
      comando_rx <= '0;
      datos_rx <= '0;
      rx_ready <= 1'b0;
      bussy <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
      bit_st <= bit_n;
      asm_st <= asm_n;
      cc <= cc_n;
      bc <= bc_n;
      shift <= shift_n;
      cmd_hold <= cmd_hold_n;
      tmr <= tmr_n;
      comando_rx <= load ? cmd_hold : comando_rx;
      datos_rx <= load ? shift : datos_rx;
      rx_ready <= load | (rx_ready & ~ack_j1);
      bussy <= (bit_n != IDLE) | (asm_n == WAIT_DATA);
      frame_err <= ferr;
      overrun <= ovr;
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: table-driven and scoreboard bench for uart_cmd_rx
module tb_uart_cmd_rx;
  localparam int CPB = 32;
  localparam int TOB = 20;
  localparam int LAT = CPB * 19 / 2 + 3;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, ack_j1 = 1'b0;
  logic [7:0] comando_rx, datos_rx;
  logic rx_ready, bussy, frame_err, overrun;
  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .ack_j1(ack_j1),
    .comando_rx(comando_rx), .datos_rx(datos_rx), .rx_ready(rx_ready),
    .bussy(bussy), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic pre_en;
    logic [7:0] pre;
    int pre_gap;
    logic [7:0] cmd;
    logic [7:0] dat;
    int gap;
    logic [7:0] exp_cmd;
    logic [7:0] exp_dat;
  } vec_t;
  vec_t vecs[6];
  logic [15:0] exp_q[$];
  logic [15:0] obs[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, last_start = 0, sent_n = 0;
  int ferr_n = 0, ferr_run = 0, ferr_max = 0, ovr_n = 0, ovr_cyc = 0;
  logic prev_rdy = 1'b0;
  logic [15:0] prev_out = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && rx_ready && (!prev_rdy || {comando_rx, datos_rx} != prev_out))
      obs.push_back({comando_rx, datos_rx});
    prev_rdy = rx_ready & ~rst;
    prev_out = {comando_rx, datos_rx};
    if (frame_err) begin
      ferr_n++;
      ferr_run++;
    end else begin
      if (ferr_run > ferr_max) ferr_max = ferr_run;
      ferr_run = 0;
    end
    if (overrun) begin
      ovr_n++;
      ovr_cyc = cyc;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    last_start = cyc;
    sent_n++;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
  endtask
  task automatic idle_bits(input int n);
    repeat (n * CPB) @(posedge clk);
  endtask
  task automatic wait_pair(input string nm);
    logic [15:0] e, o;
    int n;
    n = 0;
    while (obs.size() == 0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    if (obs.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no pair after %0d cycles, expected %0h", nm, n, e);
    end else begin
      o = obs.pop_front();
      chk({nm, "_cmd"}, o[15:8], e[15:8]);
      chk({nm, "_dat"}, o[7:0], e[7:0]);
    end
  endtask
  task automatic ack_pulse(input string nm);
    @(posedge clk);
    #1 ack_j1 = 1'b1;
    @(posedge clk);
    #1 ack_j1 = 1'b0;
    @(negedge clk);
    chk({nm, "_ack_clears"}, rx_ready, 0);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_cmd"}, comando_rx, 0);
    chk({nm, "_dat"}, datos_rx, 0);
    chk({nm, "_rdy"}, rx_ready, 0);
    chk({nm, "_bussy"}, bussy, 0);
    chk({nm, "_ferr"}, frame_err, 0);
    chk({nm, "_ovr"}, overrun, 0);
  endtask
  task automatic send_pair(input logic [7:0] c, input logic [7:0] d, input int gap);
    send_byte(c, 1'b1);
    idle_bits(gap);
    send_byte(d, 1'b1);
  endtask
  initial begin
    int f0, o0, s0, lat, n;
    vecs[0] = '{1'b0, 8'h00, 0, 8'h03, 8'hA5, 1, 8'h03, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 0, 8'h5A, 8'hC3, 0, 8'h5A, 8'hC3};
    vecs[2] = '{1'b0, 8'h00, 0, 8'hFF, 8'h00, 2, 8'hFF, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 0, 8'h00, 8'hFF, 1, 8'h00, 8'hFF};
    vecs[4] = '{1'b0, 8'h00, 0, 8'h12, 8'h34, 18, 8'h12, 8'h34};
    vecs[5] = '{1'b1, 8'h05, 25, 8'h01, 8'h02, 1, 8'h01, 8'h02};
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_zero("in_reset");
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("after_reset");
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_n;
      o0 = ovr_n;
      if (vecs[i].pre_en) begin
        send_byte(vecs[i].pre, 1'b1);
        idle_bits(vecs[i].pre_gap);
      end
      send_byte(vecs[i].cmd, 1'b1);
      idle_bits(vecs[i].gap);
      exp_q.push_back({vecs[i].exp_cmd, vecs[i].exp_dat});
      send_byte(vecs[i].dat, 1'b1);
      wait_pair($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_pulses", i), (ferr_n - f0) + (ovr_n - o0), 0);
      ack_pulse($sformatf("vec%0d", i));
    end
    idle_bits(2);
    f0 = ferr_n;
    o0 = ovr_n;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    chk("glitch_bussy_high", bussy, 1);
    n = 0;
    while (bussy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("glitch_bussy_low", bussy, 0);
    idle_bits(2);
    chk("glitch_no_pulses", (ferr_n - f0) + (ovr_n - o0), 0);
    chk("glitch_no_pair", obs.size() + rx_ready, 0);
    f0 = ferr_n;
    ferr_max = 0;
    send_byte(8'h10, 1'b0);
    idle_bits(2);
    chk("ferr_count", ferr_n - f0, 1);
    chk("ferr_width", ferr_max, 1);
    chk("ferr_no_ready", rx_ready, 0);
    send_byte(8'h77, 1'b1);
    idle_bits(1);
    chk("wait_data_bussy", bussy, 1);
    send_byte(8'h10, 1'b0);
    idle_bits(1);
    chk("ferr_in_wait_data", ferr_n - f0, 2);
    exp_q.push_back(16'h0102);
    send_pair(8'h01, 8'h02, 1);
    wait_pair("after_ferr");
    ack_pulse("after_ferr");
    f0 = ferr_n;
    @(posedge clk);
    #1 rx = 1'b0;
    idle_bits(12);
    #1 rx = 1'b1;
    idle_bits(2);
    chk("break_one_ferr", ferr_n - f0, 1);
    chk("break_idle", {bussy, rx_ready}, 0);
    o0 = ovr_n;
    exp_q.push_back(16'h1122);
    send_pair(8'h11, 8'h22, 1);
    wait_pair("ovr_first");
    send_pair(8'h33, 8'h44, 1);
    idle_bits(2);
    chk("ovr_count", ovr_n - o0, 1);
    chk("ovr_hold", {comando_rx, datos_rx}, 16'h1122);
    chk("ovr_ready", rx_ready, 1);
    chk("ovr_no_pair", obs.size(), 0);
    lat = ovr_cyc - last_start;
    chk("latency_window", lat >= LAT - 2 && lat <= LAT + 2, 1);
    if (!(lat >= LAT - 2 && lat <= LAT + 2)) lat = LAT;
    o0 = ovr_n;
    s0 = sent_n;
    exp_q.push_back(16'h3344);
    fork
      send_pair(8'h33, 8'h44, 1);
      begin
        wait (sent_n == s0 + 2);
        repeat (lat - 1) @(posedge clk);
        #1 ack_j1 = 1'b1;
        @(posedge clk);
        #1 ack_j1 = 1'b0;
      end
    join
    wait_pair("ack_same_cycle");
    chk("ack_same_no_ovr", ovr_n - o0, 0);
    ack_pulse("ack_same_cycle");
    s0 = sent_n;
    fork
      send_byte(8'h5A, 1'b1);
      begin
        wait (sent_n == s0 + 1);
        repeat (4 * CPB + 3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero("mid_byte_reset");
      end
    join
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_bits(1);
    exp_q.push_back(16'h0708);
    send_pair(8'h07, 8'h08, 1);
    wait_pair("post_reset");
    idle_bits(1);
    chk("final_no_extra", obs.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
